arm_muldiv: RTL and testbench

//  Iterative multiply/divide coprocessor for the ARM datapath; adds MUL/UMULL/SMULL/UDIV/SDIV.
//  One result bit per cycle; operands are latched on start and results arrive after a fixed latency.

---
 rtl/arm_muldiv.sv | 146 ++++++++++++++
 tb/tb_arm_muldiv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/arm_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one step per clock.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier is zero.
module arm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             div_by_zero
);
    localparam int CNTW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nx;

    logic [1:0]         op_q;
    logic               sa, sb, dz, ovf;
    logic [WIDTH-1:0]   a_q, mq;
    logic [2*WIDTH-1:0] acc, md;
    logic [CNTW-1:0]    cnt;

    logic               accept, last;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     dshift, rem_nx;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, lo_fix, hi_fix;
    logic [3:0]         fl_fix;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN) || (state == FIX);
    assign done   = (state == DONE);

    // Signed ops work on magnitudes; the signs are re-applied in FIX.
    assign sgn_a = op[0] & a[WIDTH-1];
    assign sgn_b = op[0] & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;

    // Restoring-divide step: remainder in acc, dividend shifting out of mq into the quotient.
    assign dshift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign ge     = dshift >= {1'b0, md[WIDTH-1:0]};
    assign rem_nx = ge ? (dshift - {1'b0, md[WIDTH-1:0]}) : dshift;

    always_comb begin
        last = (cnt == CNTW'(1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!op_q[1] && mq[WIDTH-1:1] == '0)
            last = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        prod   = (sa ^ sb) ? -acc : acc;
        quo    = (sa ^ sb) ? -mq : mq;
        rem    = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        lo_fix = prod[WIDTH-1:0];
        hi_fix = prod[2*WIDTH-1:WIDTH];
        fl_fix = {prod[2*WIDTH-1], prod == '0, 2'b00};
        if (op_q[1]) begin
            if (dz) begin
                lo_fix = '1;
                hi_fix = a_q;
                fl_fix = 4'b1010;
            end else begin
                // Overflow case falls out naturally: quotient bits are already 100..0.
                lo_fix = quo;
                hi_fix = rem;
                fl_fix = {quo[WIDTH-1], quo == '0, 1'b0, ovf};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            a_q         <= '0;
            mq          <= '0;
            acc         <= '0;
            md          <= '0;
            cnt         <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            flags       <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            sa   <= sgn_a;
            sb   <= sgn_b;
            dz   <= op[1] && (b == '0);
            ovf  <= (op == 2'b11) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            a_q  <= a;
            acc  <= '0;
            md   <= {{WIDTH{1'b0}}, op[1] ? mag_b : mag_a};
            mq   <= op[1] ? mag_a : mag_b;
            cnt  <= CNTW'(WIDTH);
        end else if (state == RUN) begin
            cnt <= cnt - CNTW'(1);
            if (op_q[1]) begin
                acc <= {{(WIDTH-1){1'b0}}, rem_nx};
                mq  <= {mq[WIDTH-2:0], ge};
            end else begin
                if (mq[0])
                    acc <= acc + md;
                md <= md << 1;
                mq <= mq >> 1;
            end
        end else if (state == FIX) begin
            result_lo   <= lo_fix;
            result_hi   <= hi_fix;
            flags       <= fl_fix;
            div_by_zero <= dz;
        end
    end
endmodule

// File: tb/tb_arm_muldiv.sv
// Directed bench for arm_muldiv: vector table plus re-pulse, mid-op reset and back-to-back sequences.
module tb_arm_muldiv;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] result_lo, result_hi;
    logic [3:0]  flags;

    int n_chk = 0;
    int n_fail = 0;

    arm_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .flags(flags), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, lo, hi;
        logic [3:0]  fl;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected edges from the accepting edge to the edge after which done is high.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bb);
        int steps;
        logic [31:0] m;
        steps = 32;
        m = (o[0] && bb[31]) ? -bb : bb;
`ifdef MULDIV_EARLY_TERM_EN
        if (!o[1]) begin
            steps = 1;
            for (int i = 0; i < 32; i++)
                if (m[i]) steps = i + 1;
        end
`endif
        if (m === 32'hx) steps = 0;
        return steps + 1;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_res(input string tag, input vec_t v);
        chk({tag, " lo"}, 64'(result_lo), 64'(v.lo));
        chk({tag, " hi"}, 64'(result_hi), 64'(v.hi));
        chk({tag, " flags"}, 64'(flags), 64'(v.fl));
        chk({tag, " dz"}, 64'(div_by_zero), 64'(v.dz));
    endtask

    initial begin
        int n, n2;
        bit bok;
        vec_t v;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 32'hFFFFFFFF, 4'b1000, 1'b0};
        vecs[2]  = '{2'b01, 32'h00000000, 32'h00001234, 32'h00000000, 32'h00000000, 4'b0100, 1'b0};
        vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 4'b0000, 1'b0};
        vecs[4]  = '{2'b11, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 4'b1000, 1'b0};
        vecs[5]  = '{2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005, 4'b1010, 1'b1};
        vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b1001, 1'b0};
        vecs[7]  = '{2'b00, 32'd3,        32'd5,        32'h0000000F, 32'h00000000, 4'b0000, 1'b0};
        vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0000, 1'b0};
        vecs[9]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 4'b1000, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 4'b1010, 1'b1};
        vecs[11] = '{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 4'b0000, 1'b0};
        vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 4'b1000, 1'b0};
        vecs[13] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0000, 1'b0};

        // Reset state
        #3;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst lo", 64'(result_lo), 64'd0);
        chk("rst hi", 64'(result_hi), 64'd0);
        chk("rst flags", 64'(flags), 64'd0);
        chk("rst dz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            issue(v.op, v.a, v.b);
            wait_done(n, bok);
            chk($sformatf("v%0d latency", i), 64'(n), 64'(exp_lat(v.op, v.b)));
            chk($sformatf("v%0d busy", i), 64'(bok), 64'd1);
            check_res($sformatf("v%0d", i), v);
            @(posedge clk);
            #1 chk($sformatf("v%0d done pulse", i), 64'(done), 64'd0);
        end

        // start re-pulsed during RUN with different operands: ignored
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'b10; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; a = 32'd9; b = 32'd9;
        wait_done(n, bok);
        chk("repulse latency", 64'(n + 5), 64'd33);
        check_res("repulse", vecs[0]);

        // reset mid-operation
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst lo", 64'(result_lo), 64'd0);
        chk("midrst hi", 64'(result_hi), 64'd0);
        chk("midrst flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(2'b10, 32'd100, 32'd7);
        wait_done(n, bok);
        chk("postrst latency", 64'(n), 64'd33);
        check_res("postrst", vecs[3]);
        @(posedge clk);

        // start held in DONE: back-to-back
        issue(2'b10, 32'd100, 32'd7);
        wait_done(n, bok);
        chk("b2b first done", 64'(done), 64'd1);
        check_res("b2b first", vecs[3]);
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFF9; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b busy", 64'(busy), 64'd1);
        wait_done(n2, bok);
        chk("b2b second latency", 64'(n2), 64'(exp_lat(2'b01, 32'd6)));
        check_res("b2b second", vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
